// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths: FSM states, frame width, line levels.
// The PARITY state is only used by builds that define UART_TX_PARITY_EN.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter. It counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clear holds the count at 0; bit_done is a decode of the registered count.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_done) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent 8N1 (8E1 with UART_TX_PARITY_EN).
// Frame is 10 (or 11) bit periods; tx_ready is high only in IDLE, so there is one idle cycle between frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  // The counter is held at 0 in IDLE, so the start bit gets a full period from acceptance.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q == IDLE),
    .bit_done (bit_done)
  );

  assign tx_ready = (state_q == IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shift_q   <= tx_data;
            bit_idx_q <= '0;
            tx_q      <= LINE_START;
            busy_q    <= 1'b1;
            state_q   <= START;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^tx_data;
`endif
          end
        end
        START: begin
          if (bit_done) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= LINE_IDLE;
              state_q <= STOP;
`endif
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            tx_q    <= LINE_IDLE;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= LINE_IDLE;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4; 8N1 scenarios by default, 8E1 when UART_TX_PARITY_EN is defined.
// Frame constants are written slot0 (start bit) at the LSB.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] expand(input logic [10:0] frame, input int nslots);
    logic [127:0] v = '0;
    for (int s = 0; s < nslots; s++)
      for (int c = 0; c < CPB; c++) v[s*CPB+c] = frame[s];
    return v;
  endfunction

  task automatic test_reset;
    int bad = 0;
    rst_n = 1'b0;
    repeat (5) tick;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    tick;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL post_reset_tx: got %b required 1", tx); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b required 1", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b required 0", busy); end
    repeat (100) begin
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) bad++;
      tick;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_100: got %0d non-idle cycles required 0", bad); end
  endtask

`ifndef UART_TX_PARITY_EN
  task automatic test_single_byte;
    logic [127:0] cap = '0;
    logic [127:0] exp_v = expand(10'b1101001010, 10);
    int busy_cnt = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < 40; i++) begin
      cap[i] = tx;
      if (busy === 1'b1) busy_cnt++;
      tick;
    end
    n_checks++; if (cap[39:0] !== exp_v[39:0]) begin n_fail++; $display("FAIL frame_a5: got %h required %h", cap[39:0], exp_v[39:0]); end
    n_checks++; if (busy_cnt != 40) begin n_fail++; $display("FAIL busy_len_a5: got %0d required 40", busy_cnt); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL idle_tx_a5: got %b required 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy_a5: got %b required 0", busy); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready_a5: got %b required 1", tx_ready); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] cap_t = '0;
    logic [127:0] cap_r = '0;
    logic [127:0] exp_t = expand(10'b1000000000, 10);
    logic [127:0] exp_2 = expand(10'b1111111110, 10);
    logic [127:0] exp_r = '0;
    exp_t[40] = 1'b1;
    exp_t[80:41] = exp_2[39:0];
    exp_r[40] = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b1;
    tick;
    tx_data = 8'hFF;
    for (int i = 0; i < 81; i++) begin
      cap_t[i] = tx;
      cap_r[i] = tx_ready;
      tick;
    end
    tx_valid = 1'b0;
    n_checks++; if (cap_t[80:0] !== exp_t[80:0]) begin n_fail++; $display("FAIL b2b_tx: got %h required %h", cap_t[80:0], exp_t[80:0]); end
    n_checks++; if (cap_r[80:0] !== exp_r[80:0]) begin n_fail++; $display("FAIL b2b_ready: got %h required %h", cap_r[80:0], exp_r[80:0]); end
    repeat (3) tick;
  endtask

  task automatic test_holdoff;
    logic [127:0] cap = '0;
    logic [127:0] exp_v = expand(10'b1101001010, 10);
    int rdy_cnt = 0;
    int busy_cnt = 0;
    int bad = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick;
    for (int i = 0; i < 40; i++) begin
      cap[i] = tx;
      if (tx_ready !== 1'b0) rdy_cnt++;
      if (busy === 1'b1) busy_cnt++;
      tx_data = ~tx_data;
      tx_valid = (i == 39) ? 1'b0 : ~tx_valid;
      tick;
    end
    tx_valid = 1'b0;
    n_checks++; if (cap[39:0] !== exp_v[39:0]) begin n_fail++; $display("FAIL holdoff_frame: got %h required %h", cap[39:0], exp_v[39:0]); end
    n_checks++; if (rdy_cnt != 0) begin n_fail++; $display("FAIL holdoff_ready: got %0d ready cycles required 0", rdy_cnt); end
    n_checks++; if (busy_cnt != 40) begin n_fail++; $display("FAIL holdoff_busy: got %0d required 40", busy_cnt); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL holdoff_end_ready: got %b required 1", tx_ready); end
    repeat (20) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      tick;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL holdoff_no_accept: got %0d active cycles required 0", bad); end
  endtask

  task automatic test_reset_mid_frame;
    logic [127:0] cap = '0;
    logic [127:0] exp_a = expand(10'b1001111000, 10);
    logic [127:0] exp_b = expand(10'b1100000010, 10);
    int bad = 0;
    int busy_cnt = 0;
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      cap[i] = tx;
      tick;
    end
    n_checks++; if (cap[16:0] !== exp_a[16:0]) begin n_fail++; $display("FAIL pre_reset_frame: got %h required %h", cap[16:0], exp_a[16:0]); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b required 1", tx); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    repeat (40) begin
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) bad++;
      tick;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_no_resume: got %0d active cycles required 0", bad); end
    cap = '0;
    tx_data = 8'h81; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cap[i] = tx;
      if (busy === 1'b1) busy_cnt++;
      tick;
    end
    n_checks++; if (cap[39:0] !== exp_b[39:0]) begin n_fail++; $display("FAIL frame_81: got %h required %h", cap[39:0], exp_b[39:0]); end
    n_checks++; if (busy_cnt != 40) begin n_fail++; $display("FAIL busy_len_81: got %0d required 40", busy_cnt); end
  endtask
`else
  task automatic test_parity;
    logic [127:0] cap = '0;
    logic [127:0] exp_a = expand(11'b11000001110, 11);
    logic [127:0] exp_b = expand(11'b10101001010, 11);
    int busy_cnt = 0;
    tx_data = 8'h07; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    for (int i = 0; i < 44; i++) begin
      cap[i] = tx;
      if (busy === 1'b1) busy_cnt++;
      tick;
    end
    n_checks++; if (cap[43:0] !== exp_a[43:0]) begin n_fail++; $display("FAIL parity_07: got %h required %h", cap[43:0], exp_a[43:0]); end
    n_checks++; if (busy_cnt != 44) begin n_fail++; $display("FAIL parity_busy_07: got %0d required 44", busy_cnt); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL parity_ready_07: got %b required 1", tx_ready); end
    cap = '0; busy_cnt = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    for (int i = 0; i < 44; i++) begin
      cap[i] = tx;
      if (busy === 1'b1) busy_cnt++;
      tick;
    end
    n_checks++; if (cap[43:0] !== exp_b[43:0]) begin n_fail++; $display("FAIL parity_a5: got %h required %h", cap[43:0], exp_b[43:0]); end
    n_checks++; if (busy_cnt != 44) begin n_fail++; $display("FAIL parity_busy_a5: got %0d required 44", busy_cnt); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL parity_idle_a5: got %b required 1", tx); end
  endtask
`endif

  initial begin
    test_reset;
`ifndef UART_TX_PARITY_EN
    test_single_byte;
    test_back_to_back;
    test_holdoff;
    test_reset_mid_frame;
`else
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the transmit direction of the design's UART link. It accepts one byte at a time over a valid/ready handshake and shifts it out on `tx` as an asynchronous 8N1 frame: start bit, 8 data bits LSB first, stop bit. It is paced by an internal bit-period counter and drives the line idle-high between frames.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_data  input  8  byte to transmit; sampled only on acceptance.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  transmitter can accept; high only in IDLE.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high from the acceptance edge through the last stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY (only with UART_TX_PARITY_EN), STOP.
- IDLE: tx=1, tx_ready=1, busy=0. When tx_valid && tx_ready at a rising edge:
  - latch tx_data into the shift register;
  - clear the bit index and the bit counter;
  - go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shift[0]. Each bit is held CLKS_PER_BIT cycles. After each bit, shift right and increment the bit index (3 bits). After index 7, go to PARITY, or to STOP if parity is compiled out.
- PARITY: tx = XOR of the latched byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Bit counter: counts 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT). bit_done asserts at count CLKS_PER_BIT-1 and the counter wraps to 0.
- tx_data and tx_valid are ignored outside IDLE. Changes to tx_data after acceptance do not affect the frame in flight.
- Reset values: tx=1, tx_ready=1, busy=0, state IDLE, counters 0, shift register 0.
- Reset asserted mid-frame: the frame is aborted immediately (asynchronously), tx returns to 1, and no partial byte resumes after release.

## Timing
- Acceptance at edge N: tx=0 from the cycle after edge N. busy rises at edge N and tx_ready falls at edge N.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- The data bit k (LSB first, k=0..7) period starts (1+k)·CLKS_PER_BIT cycles after the start bit begins.
- At the end of STOP, the state returns to IDLE and tx_ready=1 for at least one cycle. The minimum line-idle gap between back-to-back frames is 1 cycle. Throughput is one byte per 10·CLKS_PER_BIT+1 cycles.
- tx_ready is a decode of the registered state and has no combinational path from tx_valid.
- tx is driven from a flop; no glitches at bit boundaries.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP. It sends one even-parity bit (XOR of the 8 data bits), giving 11-bit frames (8E1).
- Undefined: the PARITY state and the parity logic are absent, giving 10-bit frames (8N1).

## Structure
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP);
  - DATA_BITS=8;
  - line level constants LINE_IDLE=1 and LINE_START=0.
- The same package is used by the matching receiver.
- Sub-module uart_baud_counter:
  - parameter CLKS_PER_BIT;
  - inputs clk, rst_n, clear;
  - output bit_done;
  - reused by the receiver.

## Test plan
- Reset: hold rst_n=0 for 5 cycles, release. Require tx=1, tx_ready=1, busy=0, and tx stays 1 for 100 idle cycles.
- Single byte, CLKS_PER_BIT=4, parity compiled out: send 0xA5. Require tx = 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 cycles, then idle high. busy must be high for 40 cycles.
- Back-to-back bytes: hold tx_valid=1 with 0x00 then 0xFF. Require a second acceptance exactly 1 IDLE cycle after the first stop bit ends, and second-frame data bits all 1.
- Handshake hold-off: toggle tx_data and pulse tx_valid during a frame. Require no acceptance, an unchanged serial pattern, and tx_ready=0 throughout.
- Parity, UART_TX_PARITY_EN defined, CLKS_PER_BIT=4: send 0x07 (parity 1) and 0xA5 (parity 0). Require 44-cycle frames with the parity bit in the 10th bit slot.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x3C. Require tx=1 in the same cycle and tx_ready=1 after release. A new byte 0x81 must then transmit correctly.
